// File: rtl/craps_pkg.sv
// Shared types and constants for the craps game: FSM states, die and sum widths.
package craps_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef logic [2:0] die_t;
  typedef logic [3:0] sum_t;

  localparam die_t DIE_MIN = 3'd1;
  localparam die_t DIE_MAX = 3'd6;

  function automatic die_t die_next(input die_t d);
    return (d == DIE_MAX) ? DIE_MIN : die_t'(d + 3'd1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for a raw push-button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_dout;
  logic [CNT_W-1:0] r_cnt;

  // Count only while the synchronized level disagrees with the output; any bounce back clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_dout) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_dout <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: debounced button, press/release FSM and two cascaded 1..6 dice counters.
module dice_roll_ctrl
  import craps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rb_raw,
  input  logic       roll_en,
  output logic       rb,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       sum_valid,
  output logic       busy
);

  logic   w_rb;
  logic   r_rb_q;
  logic   w_rb_rise;
  logic   w_start;
  logic   w_advance;
  state_t r_state;
  state_t w_state_nxt;
  die_t   r_die1;
  die_t   r_die2;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rb_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (rb_raw),
    .dout  (w_rb)
  );

  always_ff @(posedge clk) begin
    if (reset) r_rb_q <= 1'b0;
    else       r_rb_q <= w_rb;
  end

  assign w_rb_rise = w_rb & ~r_rb_q;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rb_rise && roll_en) begin
          w_state_nxt = ROLLING;
          w_start     = 1'b1;
        end
      end
      ROLLING: begin
        if (w_rb) w_advance   = 1'b1;
        else      w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Each roll starts from 1/1 so the final faces depend only on how long the button was held.
  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_die1 <= DIE_MIN;
      r_die2 <= DIE_MIN;
    end else if (w_advance) begin
      r_die1 <= die_next(r_die1);
      if (r_die1 == DIE_MAX) r_die2 <= die_next(r_die2);
    end
  end

  assign rb        = w_rb;
  assign die1      = r_die1;
  assign die2      = r_die2;
  assign sum       = sum_t'({1'b0, r_die1}) + sum_t'({1'b0, r_die2});
  assign sum_valid = (r_state == DONE);
  assign busy      = (r_state == ROLLING);

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl: reset, debounce timing, roll lengths, roll_en gating, reset mid-roll.
module tb_dice_roll_ctrl;

  logic       clk;
  logic       reset;
  logic       rb_raw;
  logic       roll_en;
  logic       rb;
  logic [2:0] die1;
  logic [2:0] die2;
  logic [3:0] sum;
  logic       sum_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  dice_roll_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rb_raw    (rb_raw),
    .roll_en   (roll_en),
    .rb        (rb),
    .die1      (die1),
    .die2      (die2),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called one cycle after busy rose: s advances have happened after s further edges.
  task automatic roll_from_busy(input int n, input int drop_at);
    int fin1;
    int fin2;
    chk("roll_start_die1", die1, 1);
    chk("roll_start_die2", die2, 1);
    if (n == 7) rb_raw = 1'b0;
    for (int s = 1; s <= n; s++) begin
      tick(1);
      if (s == drop_at) roll_en = 1'b0;
      chk("rolling_die1", die1, (s % 6) + 1);
      chk("rolling_die2", die2, ((s / 6) % 6) + 1);
      chk("rolling_busy", busy, 1);
      chk("rolling_no_valid", sum_valid, 0);
      if (s == n - 7) rb_raw = 1'b0;
    end
    fin1 = (n % 6) + 1;
    fin2 = ((n / 6) % 6) + 1;
    tick(1);
    chk("done_busy", busy, 0);
    chk("done_valid", sum_valid, 1);
    chk("done_die1", die1, fin1);
    chk("done_die2", die2, fin2);
    chk("done_sum", sum, fin1 + fin2);
    tick(1);
    chk("after_valid", sum_valid, 0);
    chk("after_busy", busy, 0);
    chk("after_sum", sum, fin1 + fin2);
    roll_en = 1'b1;
  endtask

  task automatic press_and_roll(input int n, input int drop_at);
    rb_raw = 1'b1;
    tick(7);
    chk("press_rb", rb, 1);
    chk("press_busy_low", busy, 0);
    tick(1);
    chk("press_busy_high", busy, 1);
    roll_from_busy(n, drop_at);
  endtask

  initial begin
    reset   = 1'b1;
    rb_raw  = 1'b1;
    roll_en = 1'b0;
    tick(3);
    chk("rst_die1", die1, 1);
    chk("rst_die2", die2, 1);
    chk("rst_sum", sum, 2);
    chk("rst_rb", rb, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_busy", busy, 0);
    reset  = 1'b0;
    rb_raw = 1'b0;

    for (int i = 0; i < 20; i++) begin
      rb_raw = ((i / 2) % 2 == 0);
      tick(1);
      chk("bounce_rb_low", rb, 0);
    end
    rb_raw = 1'b1;
    tick(6);
    chk("debounce_not_yet", rb, 0);
    tick(1);
    chk("debounce_rise", rb, 1);
    tick(1);
    chk("debounce_no_roll", busy, 0);
    rb_raw = 1'b0;
    tick(7);
    chk("debounce_fall", rb, 0);

    roll_en = 1'b1;
    press_and_roll(10, -1);

    roll_en = 1'b0;
    rb_raw  = 1'b1;
    tick(7);
    chk("gated_rb", rb, 1);
    tick(1);
    chk("gated_busy", busy, 0);
    roll_en = 1'b1;
    tick(4);
    chk("gated_busy_held", busy, 0);
    chk("gated_die1", die1, 5);
    chk("gated_die2", die2, 2);
    chk("gated_sum", sum, 7);
    rb_raw = 1'b0;
    tick(7);
    chk("gated_release", rb, 0);
    chk("gated_release_busy", busy, 0);
    tick(1);
    press_and_roll(8, -1);

    press_and_roll(35, -1);
    press_and_roll(36, -1);
    press_and_roll(12, 3);

    rb_raw = 1'b1;
    tick(7);
    chk("mid_rb", rb, 1);
    tick(1);
    chk("mid_busy", busy, 1);
    tick(7);
    chk("mid_die1", die1, 2);
    chk("mid_die2", die2, 2);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_die1", die1, 1);
    chk("mid_rst_die2", die2, 1);
    chk("mid_rst_sum", sum, 2);
    chk("mid_rst_valid", sum_valid, 0);
    chk("mid_rst_rb", rb, 0);
    reset = 1'b0;
    press_and_roll(9, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Roll sequencer for the craps game. It synchronizes and debounces the raw roll button and runs the two dice counters while the button is held. On release it freezes the dice and presents a one-cycle `sum_valid` strobe with the 2–12 sum. It sits between the board push-button and the craps game FSM, which consumes `rb`, `sum` and `sum_valid` and gates rolls through `roll_en`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before `rb` changes; minimum 1.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rb_raw`  in  1  raw, asynchronous, bouncing roll button.
- `roll_en`  in  1  from the game FSM; a new roll may start only while high.
- `rb`  out  1  debounced button level.
- `die1`  out  3  first die face, 1..6.
- `die2`  out  3  second die face, 1..6.
- `sum`  out  4  `die1 + die2`, 2..12, zero-extended, no overflow possible.
- `sum_valid`  out  1  one-cycle strobe when a roll completes; `sum` is final in that cycle.
- `busy`  out  1  high while a roll is in progress (state ROLLING).

## Operation
- Synchronizer: two flops on `rb_raw` produce `rb_s`.
- Debounce:
  - A counter increments while `rb_s != rb` and clears whenever `rb_s == rb`.
  - When the count reaches `DEBOUNCE_CYCLES`, `rb` toggles to `rb_s` and the counter clears.
  - The counter width is clog2(`DEBOUNCE_CYCLES`+1).
- Edge detect: `rb_rise` = `rb` & ~`rb_q`; `rb_fall` = ~`rb` & `rb_q`. Both are registered versions of `rb`.
- FSM:
  - IDLE: if `rb_rise` & `roll_en`, go to ROLLING. If `rb_rise` & ~`roll_en`, ignore the press; the button must be released and pressed again.
  - ROLLING, with `rb` = 1: the dice advance each cycle.
    - `die1` counts 1→6→1.
    - `die2` advances only on the cycle `die1` wraps from 6 to 1, and wraps 6→1 itself.
  - ROLLING, with `rb` = 0: go to DONE. The dice do not advance on that edge.
  - DONE: `sum_valid` = 1 for exactly this cycle, then unconditionally go to IDLE.
  - States 2'd3 and any other illegal encodings go to IDLE.
- `roll_en` falling during ROLLING is ignored; the roll completes normally.
- The dice hold their value in IDLE and DONE, so `sum` stays stable until the next roll starts.
- `sum` is combinational from the `die1`/`die2` registers.
- Reset values:
  - state = IDLE, `die1` = 1, `die2` = 1, `sum` = 2.
  - `rb` = 0, `sum_valid` = 0, `busy` = 0.
  - Synchronizer flops = 0, debounce counter = 0.
- Reset mid-roll returns to IDLE with dice 1/1 and no `sum_valid`.
- If the button is still held after reset, `rb` rises after debounce and starts a new roll when `roll_en` is high.

## Timing
- `rb_raw` stable at a new level from edge k: `rb` takes the new level at edge k+2+`DEBOUNCE_CYCLES`.
- Any bounce restarts the count.
- `rb` rise at edge j:
  - `rb_rise` is seen in cycle j.
  - State is ROLLING after edge j+1.
  - The first dice advance happens at edge j+2.
- A roll with `rb` high for N cycles while in ROLLING produces N advances:
  - `die1` = (N mod 6)+1.
  - `die2` = ((N div 6) mod 6)+1.
- `rb` low in ROLLING at cycle m: DONE in cycle m+1, with `sum_valid` high only there.
- Minimum spacing between `sum_valid` strobes is bounded by the debounce latency of release plus press.
- `busy` = (state == ROLLING), registered-state decode with no combinational path from inputs.

## Structure
- Shared package `craps_pkg`:
  - state enum (IDLE, ROLLING, DONE), 2-bit encoding;
  - `die_t`, 3 bits;
  - `sum_t`, 4 bits;
  - constants `DIE_MIN` = 1, `DIE_MAX` = 6.
- The game FSM imports the same package.
- One sub-module, `button_debounce`:
  - contents: synchronizer plus debounce counter;
  - parameter `DEBOUNCE_CYCLES`;
  - ports `clk`, `reset`, `din`, `dout`;
  - reused for the reset button elsewhere.
- Edge detect, FSM and dice counters are in `dice_roll_ctrl`.

## Test plan
- Reset: assert `reset` 3 cycles with `rb_raw` = 1 → `die1`=1, `die2`=1, `sum`=2, `rb`=0, `sum_valid`=0, `busy`=0.
- Debounce: `DEBOUNCE_CYCLES`=4, toggle `rb_raw` every 2 cycles for 20 cycles, then hold 1 → `rb` stays 0 during toggling and rises exactly 6 edges after the final stable level.
- Roll of N=10 advances with `roll_en`=1 → `die1`=5, `die2`=2, `sum`=7; `sum_valid` pulses 1 cycle; `busy` falls the same edge DONE is entered.
- Wrap: N=35 → 6/6, `sum`=12. N=36 → 1/1, `sum`=2. `die2` changes only on `die1` 6→1 cycles.
- `roll_en`=0 at press → no `busy`, dice unchanged. Raise `roll_en` while still held → still no roll. Release and press again → roll starts.
- Reset asserted mid-ROLLING after 7 advances → next cycle IDLE, dice 1/1, no `sum_valid`. `roll_en` dropped mid-roll → roll completes and `sum_valid` fires.
